// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised 2-read/2-write register file.
// Combinational reads, clocked writes, and a soft-clear sweep.
module reg_file_mp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 0,
  parameter int ZERO_REG   = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] WRITEDATA1,
  input  logic [ADDR_WIDTH-1:0] WRITEREG1,
  input  logic                  WRITEENABLE1,
  input  logic [DATA_WIDTH-1:0] WRITEDATA2,
  input  logic [ADDR_WIDTH-1:0] WRITEREG2,
  input  logic                  WRITEENABLE2,
  input  logic [ADDR_WIDTH-1:0] READREG1,
  input  logic [ADDR_WIDTH-1:0] READREG2,
  output logic [DATA_WIDTH-1:0] REGOUT1,
  output logic [DATA_WIDTH-1:0] REGOUT2,
  input  logic                  CLEAR,
  output logic                  BUSY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST =
    (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH+1)'(1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  busy;
  logic                  wr1_ok;
  logic                  wr2_ok;

  function automatic logic is_zero(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign busy   = (state_q == SWEEP);
  assign BUSY   = busy;
  assign wr1_ok = WRITEENABLE1 && !is_zero(WRITEREG1);
  assign wr2_ok = WRITEENABLE2 && !is_zero(WRITEREG2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    unique case (state_q)
      IDLE: begin
        // Port 2 applied last so it wins on a shared address
        if (wr1_ok) regs_d[WRITEREG1] = WRITEDATA1;
        if (wr2_ok) regs_d[WRITEREG2] = WRITEDATA2;
        if (CLEAR) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        regs_d[cnt_q[ADDR_WIDTH-1:0]] = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] v;
    v = regs_q[a];
    if (BYPASS != 0 && RESET && !busy) begin
      if (WRITEENABLE1 && WRITEREG1 == a) v = WRITEDATA1;
      if (WRITEENABLE2 && WRITEREG2 == a) v = WRITEDATA2;
    end
    if (is_zero(a)) v = '0;
    return v;
  endfunction

  assign REGOUT1 = rd(READREG1);
  assign REGOUT2 = rd(READREG2);

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: vector table plus scoreboard for reg_file_mp.
// Instances: default, bypass+zero-reg, and 16-bit/16-entry.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       we1, we2, clr;
  logic [2:0] wa1, wa2, ra1, ra2;
  logic [7:0] wd1, wd2;
  logic [7:0] a1, a2, b1, b2;
  logic       busy_a, busy_b;

  logic        we_c, clr_c, busy_c;
  logic [3:0]  wa_c, ra_c;
  logic [15:0] wd_c, c1, c2;

  reg_file_mp dut_a (
    .CLK(clk), .RESET(rst_n),
    .WRITEDATA1(wd1), .WRITEREG1(wa1), .WRITEENABLE1(we1),
    .WRITEDATA2(wd2), .WRITEREG2(wa2), .WRITEENABLE2(we2),
    .READREG1(ra1), .READREG2(ra2),
    .REGOUT1(a1), .REGOUT2(a2),
    .CLEAR(clr), .BUSY(busy_a)
  );

  reg_file_mp #(.BYPASS(1), .ZERO_REG(1)) dut_b (
    .CLK(clk), .RESET(rst_n),
    .WRITEDATA1(wd1), .WRITEREG1(wa1), .WRITEENABLE1(we1),
    .WRITEDATA2(wd2), .WRITEREG2(wa2), .WRITEENABLE2(we2),
    .READREG1(ra1), .READREG2(ra2),
    .REGOUT1(b1), .REGOUT2(b2),
    .CLEAR(clr), .BUSY(busy_b)
  );

  reg_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_c (
    .CLK(clk), .RESET(rst_n),
    .WRITEDATA1(wd_c), .WRITEREG1(wa_c), .WRITEENABLE1(we_c),
    .WRITEDATA2(16'h0000), .WRITEREG2(4'd0),
    .WRITEENABLE2(1'b0),
    .READREG1(ra_c), .READREG2(4'd0),
    .REGOUT1(c1), .REGOUT2(c2),
    .CLEAR(clr_c), .BUSY(busy_c)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] a1, a2, b1, b2;
    logic       busy;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       we1;
    logic [2:0] wa1;
    logic [7:0] wd1;
    logic       we2;
    logic [2:0] wa2;
    logic [7:0] wd2;
    logic [2:0] ra1, ra2;
    logic [7:0] ea1, ea2, eb1, eb2;
  } vec_t;
  vec_t vec [11];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we1 = 0; we2 = 0; clr = 0;
    wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0;
  endtask

  task automatic push(input logic [7:0] ea1, ea2, eb1, eb2,
                      input logic eb);
    exp_t e;
    e.a1 = ea1; e.a2 = ea2; e.b1 = eb1; e.b2 = eb2;
    e.busy = eb;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".a1"}, {8'h00, a1}, {8'h00, e.a1});
      chk({tag, ".a2"}, {8'h00, a2}, {8'h00, e.a2});
      chk({tag, ".b1"}, {8'h00, b1}, {8'h00, e.b1});
      chk({tag, ".b2"}, {8'h00, b2}, {8'h00, e.b2});
      chk({tag, ".busy_a"}, {15'h0, busy_a}, {15'h0, e.busy});
      chk({tag, ".busy_b"}, {15'h0, busy_b}, {15'h0, e.busy});
    end
  endtask

  initial begin
    int n;
    vec[0]  = '{0,0,8'h00, 0,0,8'h00, 2,6, 8'h00,8'h00,8'h00,8'h00};
    vec[1]  = '{1,7,8'd17, 0,0,8'h00, 7,0, 8'h00,8'h00,8'd17,8'h00};
    vec[2]  = '{0,0,8'h00, 0,0,8'h00, 7,0, 8'd17,8'h00,8'd17,8'h00};
    vec[3]  = '{1,3,8'd45, 1,3,8'd97, 3,3, 8'h00,8'h00,8'd97,8'd97};
    vec[4]  = '{0,0,8'h00, 0,0,8'h00, 7,3, 8'd17,8'd97,8'd17,8'd97};
    vec[5]  = '{1,0,8'h55, 0,0,8'h00, 0,0, 8'h00,8'h00,8'h00,8'h00};
    vec[6]  = '{0,0,8'h00, 0,0,8'h00, 0,3, 8'h55,8'd97,8'h00,8'd97};
    vec[7]  = '{1,6,8'h3C, 1,5,8'hA5, 5,6, 8'h00,8'h00,8'hA5,8'h3C};
    vec[8]  = '{0,0,8'h00, 0,0,8'h00, 6,5, 8'h3C,8'hA5,8'h3C,8'hA5};
    vec[9]  = '{0,0,8'h00, 1,0,8'h11, 0,7, 8'h55,8'd17,8'h00,8'd17};
    vec[10] = '{0,0,8'h00, 0,0,8'h00, 0,1, 8'h11,8'h00,8'h00,8'h00};

    idle();
    ra1 = 2; ra2 = 6;
    we_c = 0; clr_c = 0; wa_c = 0; wd_c = 0; ra_c = 0;
    rst_n = 1'b0;
    #12;
    chk("rst.a1", {8'h00, a1}, 16'h0000);
    chk("rst.b2", {8'h00, b2}, 16'h0000);
    chk("rst.busy_a", {15'h0, busy_a}, 16'h0000);
    chk("rst.busy_c", {15'h0, busy_c}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      we1 = vec[i].we1; wa1 = vec[i].wa1; wd1 = vec[i].wd1;
      we2 = vec[i].we2; wa2 = vec[i].wa2; wd2 = vec[i].wd2;
      ra1 = vec[i].ra1; ra2 = vec[i].ra2;
      push(vec[i].ea1, vec[i].ea2, vec[i].eb1, vec[i].eb2, 1'b0);
      pop_check($sformatf("vec%0d", i));
      tick();
    end

    for (int i = 0; i < 4; i++) begin
      we1 = 1; wa1 = 3'(2*i);   wd1 = 8'(10 + 2*i);
      we2 = 1; wa2 = 3'(2*i+1); wd2 = 8'(11 + 2*i);
      tick();
    end
    idle();
    clr = 1;
    tick();
    clr = 0;
    for (int c = 0; c <= 8; c++) begin
      ra1 = 3'(c);
      ra2 = 3'(c - 1);
      we1 = 0;
      if (c == 2) begin
        we1 = 1; wa1 = 5; wd1 = 8'd99;
      end
      if (c == 8) begin
        we1 = 1; wa1 = 2; wd1 = 8'd37; ra1 = 2;
        push(8'h00, 8'h00, 8'd37, 8'h00, 1'b0);
      end else begin
        push(8'(10 + c), (c == 0) ? 8'd17 : 8'h00,
             (c == 0) ? 8'h00 : 8'(10 + c),
             (c == 0) ? 8'd17 : 8'h00, 1'b1);
      end
      pop_check($sformatf("sweep%0d", c));
      tick();
    end
    idle();
    ra1 = 2; ra2 = 5;
    push(8'd37, 8'h00, 8'd37, 8'h00, 1'b0);
    pop_check("post_sweep");
    tick();

    we1 = 1; wa1 = 7; wd1 = 8'h77;
    tick();
    idle();
    clr = 1;
    tick();
    clr = 0;
    tick(); tick(); tick();
    ra1 = 7; ra2 = 7;
    chk("midsweep.busy", {15'h0, busy_a}, 16'h0001);
    chk("midsweep.reg7", {8'h00, a1}, 16'h0077);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy_a", {15'h0, busy_a}, 16'h0000);
    chk("arst.busy_b", {15'h0, busy_b}, 16'h0000);
    chk("arst.a1", {8'h00, a1}, 16'h0000);
    chk("arst.b1", {8'h00, b1}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    we1 = 1; wa1 = 6; wd1 = 8'd47; ra1 = 6;
    tick();
    idle();
    chk("relwr.a1", {8'h00, a1}, 16'd47);
    chk("relwr.b1", {8'h00, b1}, 16'd47);
    chk("relwr.a2", {8'h00, a2}, 16'h0000);
    chk("relwr.busy", {15'h0, busy_a}, 16'h0000);

    we_c = 1; wa_c = 15; wd_c = 16'hBEEF; ra_c = 15;
    tick();
    we_c = 0;
    chk("w16.rd15", c1, 16'hBEEF);
    chk("w16.rd0", c2, 16'h0000);
    clr_c = 1;
    tick();
    clr_c = 0;
    n = 0;
    for (int k = 0; k < 40 && busy_c; k++) begin
      n++;
      tick();
    end
    chk("w16.busy_cycles", 16'(n), 16'd16);
    chk("w16.cleared15", c1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
